sr_cmd_conditioner: RTL and testbench
=====================================

# sr_cmd_conditioner

Upstream command stage for the team's SR flip-flop: takes two raw, possibly bouncy and asynchronous set/clear request lines, synchronises and debounces each, detects rising edges, and emits single-cycle S and R pulses. Guarantees S and R are never high together, so the downstream flop never sees the 2'b11 (undefined) command. Also reports conflicts and dropped requests.

## Interface
- DEB_CYCLES, 4: consecutive differing samples needed to flip a debounced level (≥1).
- HOLDOFF, 2: lockout cycles after each emitted pulse (≥0).
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset; one clock domain only.
- set_raw  in  1  raw set request (level, may bounce, asynchronous).
- clr_raw  in  1  raw clear request (level, may bounce, asynchronous).
- S  out  1  one-cycle set pulse to SR flop.
- R  out  1  one-cycle reset pulse to SR flop.
- set_lvl  out  1  debounced set level.
- clr_lvl  out  1  debounced clear level.
- conflict  out  1  one-cycle pulse: set and clear rises in the same cycle.
- dropped  out  1  one-cycle pulse: a rise arrived during PULSE/HOLD and was discarded.

## Operation
- Reset (reset_n low, asynchronous): S, R, set_lvl, clr_lvl, conflict, dropped, all counters, sync flops = 0; FSM = IDLE. Reset mid-debounce or mid-holdoff discards all progress.
- Per channel: sample = synchronised raw. If sample == lvl, cnt <= 0. Otherwise cnt increments; on the DEB_CYCLES-th consecutive differing sample, lvl <= sample and cnt <= 0. A single matching sample restarts the count.
- rise = lvl & ~lvl_d, where lvl_d is lvl delayed one cycle. Falling edges produce no pulse.
- FSM: IDLE, PULSE, HOLD.
  - IDLE, set rise only: S <= 1 → PULSE. Clear rise only: R <= 1 → PULSE. Both rises: conflict <= 1, no S/R, stay IDLE.
  - PULSE: S, R <= 0. If HOLDOFF > 0, load hcnt = HOLDOFF → HOLD; otherwise → IDLE.
  - HOLD: hcnt decrements; at 1 → IDLE.
  - Any rise seen in PULSE or HOLD: dropped <= 1 for one cycle; the request is not queued.
- S and R are registered and mutually exclusive by construction.

## Timing
- Sync enabled: raw change sampled at edge 1. Synchroniser output at edge 2. lvl flips at edge DEB_CYCLES+2. S/R is high for one cycle after edge DEB_CYCLES+3.
- Sync disabled: subtract 2 edges. S/R is high after edge DEB_CYCLES+1.
- Minimum spacing between consecutive S/R pulses: 2+HOLDOFF cycles.
- set_lvl and clr_lvl follow lvl with no added delay. conflict and dropped are one cycle wide.

## Configuration
- SR_CMD_SYNC_EN defined: each raw input passes through a 2-flop synchroniser (reset 0) before debounce; latency includes the +2 above.
- SR_CMD_SYNC_EN undefined: raw inputs feed the debounce directly. Legal only when the inputs are already synchronous to clk.

## Structure
- Package sr_cmd_pkg: FSM state enum (IDLE/PULSE/HOLD) and a counter-width function (clog2-based) for the DEB_CYCLES and HOLDOFF counters.
- Sub-module sr_cmd_debounce_ch: synchroniser, debounce counter, lvl, lvl_d, rise. Instantiated twice (set, clear). The top level holds the FSM, holdoff counter and output registers.

## Test plan
- Clean set (DEB_CYCLES=4, sync on): set_raw 0→1 before edge 1 → set_lvl=1 after edge 6; S=1 only after edge 7; R=0 throughout.
- Bounce: set_raw toggles 1,0,1,0 over four cycles, then holds 1 → set_lvl flips only after 4 stable samples; exactly one S pulse.
- Simultaneous: set_raw and clr_raw rise on the same cycle → one conflict pulse; S=R=0; FSM stays IDLE.
- Holdoff (HOLDOFF=2): clr rise lands 1 cycle after an S pulse → dropped=1, no R; a clr rise after holdoff expires → R pulse.
- Async reset mid-operation: assert reset_n low mid-debounce and mid-HOLD → all outputs 0 immediately. After release, a still-high raw input needs a full re-debounce before any pulse.
- Invariant across random stimulus: S&R is never 1.

Source files
------------

// File: rtl/sr_cmd_pkg.sv
// Shared types for the SR command conditioner: FSM state encoding and counter sizing.
package sr_cmd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      HOLD  = 2'd2
   } sr_state_e;

   // Bits needed to hold values 0..max_val; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/sr_cmd_debounce_ch.sv
// One request channel: optional 2-flop synchroniser (SR_CMD_SYNC_EN), debounce counter,
// debounced level and its rising-edge strobe.
module sr_cmd_debounce_ch
   import sr_cmd_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_raw,
   output logic o_lvl,
   output logic o_rise_c
);

   localparam int unsigned CW = cnt_width(DEB_CYCLES);

   logic          w_sample;
   logic [CW-1:0] r_cnt;
   logic          r_lvl;
   logic          r_lvl_d;

`ifdef SR_CMD_SYNC_EN
   logic [1:0] r_sync;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync <= 2'b00;
      end else begin
         r_sync <= {r_sync[0], i_raw};
      end
   end

   assign w_sample = r_sync[1];
`else
   assign w_sample = i_raw;
`endif

   // Level flips only after DEB_CYCLES consecutive samples that disagree with it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt   <= '0;
         r_lvl   <= 1'b0;
         r_lvl_d <= 1'b0;
      end else begin
         r_lvl_d <= r_lvl;
         if (w_sample == r_lvl) begin
            r_cnt <= '0;
         end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
            r_lvl <= w_sample;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign o_lvl    = r_lvl;
   assign o_rise_c = r_lvl & ~r_lvl_d;

endmodule

// File: rtl/sr_cmd_conditioner.sv
// Debounced set/clear requests to mutually exclusive single-cycle S/R pulses with holdoff,
// plus conflict/dropped reporting. SR_CMD_SYNC_EN adds input synchronisers.
module sr_cmd_conditioner
   import sr_cmd_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = 4,
   parameter int unsigned HOLDOFF    = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic set_raw,
   input  logic clr_raw,
   output logic S,
   output logic R,
   output logic set_lvl,
   output logic clr_lvl,
   output logic conflict,
   output logic dropped
);

   localparam int unsigned HW      = cnt_width(HOLDOFF);
   localparam bit          HOLD_EN = (HOLDOFF != 0);

   logic          w_set_rise_c;
   logic          w_clr_rise_c;
   logic          w_set_lvl;
   logic          w_clr_lvl;

   sr_state_e     r_state;
   sr_state_e     w_state_nxt;
   logic [HW-1:0] r_hcnt;
   logic [HW-1:0] w_hcnt_nxt;
   logic          r_s;
   logic          r_r;
   logic          r_conflict;
   logic          r_dropped;
   logic          w_s_nxt;
   logic          w_r_nxt;
   logic          w_conflict_nxt;
   logic          w_dropped_nxt;

   sr_cmd_debounce_ch #(.DEB_CYCLES(DEB_CYCLES)) u_set_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_raw    (set_raw),
      .o_lvl    (w_set_lvl),
      .o_rise_c (w_set_rise_c)
   );

   sr_cmd_debounce_ch #(.DEB_CYCLES(DEB_CYCLES)) u_clr_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_raw    (clr_raw),
      .o_lvl    (w_clr_lvl),
      .o_rise_c (w_clr_rise_c)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_hcnt     <= '0;
         r_s        <= 1'b0;
         r_r        <= 1'b0;
         r_conflict <= 1'b0;
         r_dropped  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_hcnt     <= w_hcnt_nxt;
         r_s        <= w_s_nxt;
         r_r        <= w_r_nxt;
         r_conflict <= w_conflict_nxt;
         r_dropped  <= w_dropped_nxt;
      end
   end

   // Only IDLE can launch a pulse, and it launches at most one of S/R.
   always_comb begin
      w_state_nxt    = r_state;
      w_hcnt_nxt     = r_hcnt;
      w_s_nxt        = 1'b0;
      w_r_nxt        = 1'b0;
      w_conflict_nxt = 1'b0;
      w_dropped_nxt  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_set_rise_c && w_clr_rise_c) begin
               w_conflict_nxt = 1'b1;
            end else if (w_set_rise_c) begin
               w_s_nxt     = 1'b1;
               w_state_nxt = PULSE;
            end else if (w_clr_rise_c) begin
               w_r_nxt     = 1'b1;
               w_state_nxt = PULSE;
            end
         end
         PULSE: begin
            w_dropped_nxt = w_set_rise_c | w_clr_rise_c;
            if (HOLD_EN) begin
               w_hcnt_nxt  = HW'(HOLDOFF);
               w_state_nxt = HOLD;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         HOLD: begin
            w_dropped_nxt = w_set_rise_c | w_clr_rise_c;
            if (r_hcnt <= HW'(1)) begin
               w_hcnt_nxt  = '0;
               w_state_nxt = IDLE;
            end else begin
               w_hcnt_nxt = r_hcnt - HW'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_hcnt_nxt  = '0;
         end
      endcase
   end

   assign S        = r_s;
   assign R        = r_r;
   assign set_lvl  = w_set_lvl;
   assign clr_lvl  = w_clr_lvl;
   assign conflict = r_conflict;
   assign dropped  = r_dropped;

endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// Directed bench for sr_cmd_conditioner: per-cycle vector table, async reset sequences,
// and a random run checking S/R exclusivity. Latency tracks SR_CMD_SYNC_EN.
`timescale 1ns/1ps
module tb_sr_cmd_conditioner;

   localparam int DEB = 4;
   localparam int HOLDOFF_P = 2;
`ifdef SR_CMD_SYNC_EN
   localparam int SY = 2;
`else
   localparam int SY = 0;
`endif
   // Vectors from a raw change (applied in vector k) to debounced level visible is L-1; pulse at L.
   localparam int L = DEB + SY;
   localparam int N = 215;

   logic clk = 1'b0;
   logic reset_n;
   logic set_raw;
   logic clr_raw;
   logic S, R, set_lvl, clr_lvl, conflict, dropped;
   logic [5:0] w_obs;

   // expv bit order: {S, R, set_lvl, clr_lvl, conflict, dropped}
   typedef struct packed {
      logic       set_raw;
      logic       clr_raw;
      logic [5:0] expv;
   } vec_t;

   vec_t vecs [N];
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   assign w_obs = {S, R, set_lvl, clr_lvl, conflict, dropped};

   sr_cmd_conditioner #(.DEB_CYCLES(DEB), .HOLDOFF(HOLDOFF_P)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .set_raw  (set_raw),
      .clr_raw  (clr_raw),
      .S        (S),
      .R        (R),
      .set_lvl  (set_lvl),
      .clr_lvl  (clr_lvl),
      .conflict (conflict),
      .dropped  (dropped)
   );

   task automatic check(input string name, input logic [5:0] act, input logic [5:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: {S,R,set_lvl,clr_lvl,conflict,dropped} got %b expected %b",
                  name, act, expv);
      end
   endtask

   // Raw high for len vectors from st; when the run is long enough, level follows L-1 later.
   task automatic raw_run(input int ch, input int st, input int len, input bit lvl_exp);
      for (int i = st; i < st + len; i++) begin
         if (ch == 0) vecs[i].set_raw = 1'b1;
         else         vecs[i].clr_raw = 1'b1;
      end
      if (lvl_exp) begin
         for (int i = st + L - 1; i < st + len + L - 1; i++) begin
            if (ch == 0) vecs[i].expv[3] = 1'b1;
            else         vecs[i].expv[2] = 1'b1;
         end
      end
   endtask

   task automatic tick_check(input string name, input logic [5:0] expv);
      @(posedge clk);
      #1;
      check(name, w_obs, expv);
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < N; i++) vecs[i] = '0;
      // Clean set: level after L-1, single S at L.
      raw_run(0, 2, 12, 1'b1);
      vecs[2 + L].expv[5] = 1'b1;
      // Glitches shorter than DEB never move the level.
      raw_run(0, 20, 3, 1'b0);
      raw_run(1, 24, 3, 1'b0);
      // Bounce 1,0,1,0 then stable high.
      vecs[32].set_raw = 1'b1;
      vecs[34].set_raw = 1'b1;
      raw_run(0, 36, 12, 1'b1);
      vecs[36 + L].expv[5] = 1'b1;
      // Simultaneous rises: conflict only.
      raw_run(0, 60, 12, 1'b1);
      raw_run(1, 60, 12, 1'b1);
      vecs[60 + L].expv[1] = 1'b1;
      // Clear rise during HOLD (first holdoff cycle): dropped, no R.
      raw_run(0, 85, 12, 1'b1);
      raw_run(1, 87, 12, 1'b1);
      vecs[85 + L].expv[5] = 1'b1;
      vecs[87 + L].expv[0] = 1'b1;
      // Clear rise in last holdoff cycle: still dropped.
      raw_run(0, 110, 12, 1'b1);
      raw_run(1, 113, 12, 1'b1);
      vecs[110 + L].expv[5] = 1'b1;
      vecs[113 + L].expv[0] = 1'b1;
      // Clear rise right after holdoff: R at minimum spacing 2+HOLDOFF.
      raw_run(0, 135, 12, 1'b1);
      raw_run(1, 135 + 2 + HOLDOFF_P, 12, 1'b1);
      vecs[135 + L].expv[5] = 1'b1;
      vecs[135 + 2 + HOLDOFF_P + L].expv[4] = 1'b1;
      // Set rise while R is in PULSE: dropped.
      raw_run(1, 160, 12, 1'b1);
      raw_run(0, 161, 12, 1'b1);
      vecs[160 + L].expv[4] = 1'b1;
      vecs[161 + L].expv[0] = 1'b1;
      // Clean clear alone.
      raw_run(1, 185, 12, 1'b1);
      vecs[185 + L].expv[4] = 1'b1;

      reset_n = 1'b0;
      set_raw = 1'b0;
      clr_raw = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", w_obs, 6'b000000);
      @(negedge clk);
      reset_n = 1'b1;

      for (int k = 0; k < N; k++) begin
         set_raw = vecs[k].set_raw;
         clr_raw = vecs[k].clr_raw;
         tick_check($sformatf("vec%0d", k), vecs[k].expv);
      end

      // Reset mid-debounce, then a held input must re-debounce from scratch.
      set_raw = 1'b1;
      for (int k = 0; k < 3; k++) tick_check($sformatf("deb_pre%0d", k), 6'b000000);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("reset_mid_deb", w_obs, 6'b000000);
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k <= L; k++) begin
         tick_check($sformatf("redeb_a%0d", k),
                    {(k == L), 1'b0, (k >= L - 1), 3'b000});
      end
      // Now in PULSE; one more edge enters HOLD, then reset there.
      tick_check("enter_hold", 6'b001000);
      #2;
      reset_n = 1'b0;
      #1;
      check("reset_mid_hold", w_obs, 6'b000000);
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k <= L; k++) begin
         tick_check($sformatf("redeb_b%0d", k),
                    {(k == L), 1'b0, (k >= L - 1), 3'b000});
      end
      set_raw = 1'b0;
      repeat (L + 6) @(posedge clk);
      @(negedge clk);

      // Random toggling: S and R must never be high together.
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 3) == 0) set_raw = ~set_raw;
         if ($urandom_range(0, 3) == 0) clr_raw = ~clr_raw;
         @(posedge clk);
         #1;
         check($sformatf("sr_excl%0d", k), {4'b0000, S & R, conflict & (S | R)}, 6'b000000);
         @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
